// File: rtl/fp_add_align.sv
// Add/subtract front end for {s, e, f} floats: unpack, magnitude order,
// align the smaller fraction and add or subtract, over three stages.
module fp_add_align #(
  parameter int P_EXP_W  = 5,
  parameter int P_FRAC_W = 16,
  parameter int P_TAG_W  = 4
) (
  input  logic                     clk_core,
  input  logic                     rst_x,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [P_EXP_W+P_FRAC_W:0] i_a,
  input  logic [P_EXP_W+P_FRAC_W:0] i_b,
  input  logic                     i_sub,
  input  logic [P_TAG_W-1:0]       i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_s,
  output logic [P_EXP_W-1:0]       o_e,
  output logic [P_FRAC_W:0]        o_f,
  output logic [P_TAG_W-1:0]       o_tag
);

  localparam int EW = P_EXP_W;
  localparam int FW = P_FRAC_W;
  localparam int W  = 1 + EW + FW;

  logic en1, en2, en3;
  logic v1, v2, v3;

  assign en3     = !v3 || i_ready;
  assign en2     = !v2 || en3;
  assign en1     = !v1 || en2;
  assign o_ready = en1;
  assign o_valid = v3;

  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [FW-1:0] fa, fb;
  logic          swap;

  // A zero exponent means zero; any stored fraction bits are ignored
  always_comb begin
    sa   = i_a[W-1];
    ea   = i_a[W-2 -: EW];
    fa   = (ea == '0) ? '0 : i_a[FW-1:0];
    sb   = i_b[W-1] ^ i_sub;
    eb   = i_b[W-2 -: EW];
    fb   = (eb == '0) ? '0 : i_b[FW-1:0];
    swap = {eb, fb} > {ea, fa};
  end

  logic          s_l1, s_s1, op1;
  logic [EW-1:0] e_l1, d1;
  logic [FW-1:0] f_l1, f_s1;
  logic [P_TAG_W-1:0] tag1;

  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      v1   <= 1'b0;
      s_l1 <= 1'b0;
      s_s1 <= 1'b0;
      op1  <= 1'b0;
      e_l1 <= '0;
      d1   <= '0;
      f_l1 <= '0;
      f_s1 <= '0;
      tag1 <= '0;
    end else if (en1) begin
      v1   <= i_valid;
      s_l1 <= swap ? sb : sa;
      s_s1 <= swap ? sa : sb;
      op1  <= sa ^ sb;
      e_l1 <= swap ? eb : ea;
      d1   <= swap ? eb - ea : ea - eb;
      f_l1 <= swap ? fb : fa;
      f_s1 <= swap ? fa : fb;
      tag1 <= i_tag;
    end
  end

  logic [FW-1:0] f_al;

  always_comb begin
    f_al = '0;
    if (32'(d1) < FW)
      f_al = f_s1 >> d1;
  end

  logic          s_l2, op2;
  logic [EW-1:0] e_l2;
  logic [FW-1:0] f_l2, f_al2;
  logic [P_TAG_W-1:0] tag2;

  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      v2    <= 1'b0;
      s_l2  <= 1'b0;
      op2   <= 1'b0;
      e_l2  <= '0;
      f_l2  <= '0;
      f_al2 <= '0;
      tag2  <= '0;
    end else if (en2) begin
      v2    <= v1;
      s_l2  <= s_l1;
      op2   <= op1;
      e_l2  <= e_l1;
      f_l2  <= f_l1;
      f_al2 <= f_al;
      tag2  <= tag1;
    end
  end

  logic [FW:0] sum;

  // The swap guarantees the subtraction never goes negative
  always_comb begin
    if (op2)
      sum = {1'b0, f_l2} - {1'b0, f_al2};
    else
      sum = {1'b0, f_l2} + {1'b0, f_al2};
  end

  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      v3    <= 1'b0;
      o_s   <= 1'b0;
      o_e   <= '0;
      o_f   <= '0;
      o_tag <= '0;
    end else if (en3) begin
      v3    <= v2;
      o_s   <= (sum == '0) ? 1'b0 : s_l2;
      o_e   <= e_l2;
      o_f   <= sum;
      o_tag <= tag2;
    end
  end

  logic unused;
  assign unused = s_s1;

endmodule
